// File: rtl/cpu_debug_ocimem_arbiter.sv
// ---------------------------------------------------------------------------
// cpu_debug_ocimem_arbiter
//
// Shares the CPU debug (OCI) memory port between the JTAG debug slave and a
// local host master. Accesses are serialised through a small FSM
// (IDLE -> ISSUE -> [RDATA] -> DONE). Round-robin priority is used when both
// sides are pending. A stall counter aborts any access that mem_wait holds
// off for TIMEOUT cycles.
//
// Ports
//   clk, reset_n            clock, asynchronous active-low reset
//   take_action_ocimem_a/b  JTAG command pulses, payload on jdo
//   MonDReg                 last JTAG read data
//   monitor_ready           1 when no JTAG op is pending or in flight
//   monitor_error           sticky JTAG overrun / timeout flag
//   hst_*                   host request/response handshake
//   mem_*                   OCI memory port (mem_wait stalls, read data
//                           arrives one cycle after acceptance)
// ---------------------------------------------------------------------------
module cpu_debug_ocimem_arbiter #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic [37:0]       jdo,
    output logic [DATA_W-1:0] MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error,
    input  logic              hst_req,
    input  logic              hst_wr,
    input  logic [ADDR_W-1:0] hst_addr,
    input  logic [DATA_W-1:0] hst_wdata,
    output logic              hst_gnt,
    output logic              hst_rvalid,
    output logic [DATA_W-1:0] hst_rdata,
    output logic              hst_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_wait,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RDATA = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Abort fires on the stalled cycle where the count of earlier stalls
    // equals TIMEOUT-1, i.e. the TIMEOUT-th consecutive stalled cycle.
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    state_t            state, state_next;

    // JTAG single-entry command slot and address pointer
    logic              jtag_pend;
    logic              jtag_we;
    logic [DATA_W-1:0] jtag_wdata;
    logic [ADDR_W-1:0] jtag_addr;

    // Registered copy of the winning request
    logic              last_jtag;
    logic              cur_jtag;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [15:0]       stall_cnt;

    logic              mon_err;
    logic [DATA_W-1:0] mon_dreg;
    logic [DATA_W-1:0] hst_rdata_hold;

    logic              any_pend;
    logic              pick_jtag;
    logic              accept;
    logic              timeout_hit;
    logic              jtag_done;
    logic              jtag_abort;
    logic              jdo_unused;

    // Bits above the command fields carry nothing for this block.
    assign jdo_unused  = ^jdo[37:36];

    assign any_pend    = jtag_pend | hst_req;
    // JTAG wins unless the host is also pending and JTAG had the last turn.
    assign pick_jtag   = jtag_pend & (~hst_req | ~last_jtag);
    assign accept      = (state == S_ISSUE) & ~mem_wait;
    assign timeout_hit = (state == S_ISSUE) & mem_wait & (stall_cnt == TO_LAST);
    assign jtag_done   = (state == S_DONE) & cur_jtag;
    assign jtag_abort  = timeout_hit & cur_jtag;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (any_pend) state_next = S_ISSUE;
            S_ISSUE: begin
                if (!mem_wait)       state_next = req_we ? S_DONE : S_RDATA;
                else if (timeout_hit) state_next = S_IDLE;
            end
            S_RDATA: state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        hst_gnt       = 1'b0;
        hst_rvalid    = 1'b0;
        hst_err       = 1'b0;
        mem_addr      = req_addr;
        mem_wdata     = req_wdata;
        MonDReg       = mon_dreg;
        monitor_ready = ~jtag_pend;
        monitor_error = mon_err;
        if (state == S_ISSUE) begin
            mem_req = 1'b1;
            mem_we  = req_we;
        end
        hst_gnt    = accept & ~cur_jtag;
        hst_err    = timeout_hit & ~cur_jtag;
        hst_rvalid = (state == S_RDATA) & ~cur_jtag;
        // Present read data in the rvalid cycle, then hold it.
        hst_rdata  = hst_rvalid ? mem_rdata : hst_rdata_hold;
    end

    // ---------------- Request capture / read data ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_jtag      <= 1'b0;
            cur_jtag       <= 1'b0;
            req_we         <= 1'b0;
            req_addr       <= '0;
            req_wdata      <= '0;
            stall_cnt      <= '0;
            mon_dreg       <= '0;
            hst_rdata_hold <= '0;
        end else begin
            if (state == S_IDLE && any_pend) begin
                cur_jtag  <= pick_jtag;
                last_jtag <= pick_jtag;
                req_we    <= pick_jtag ? jtag_we    : hst_wr;
                req_addr  <= pick_jtag ? jtag_addr  : hst_addr;
                req_wdata <= pick_jtag ? jtag_wdata : hst_wdata;
                stall_cnt <= '0;
            end else if (state == S_ISSUE && mem_wait) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
            if (state == S_RDATA) begin
                if (cur_jtag) mon_dreg       <= mem_rdata;
                else          hst_rdata_hold <= mem_rdata;
            end
        end
    end

    // ---------------- JTAG command slot ----------------
    // Completion and abort only happen while the slot is full, and pulses
    // are only accepted while it is empty, so the two halves never collide.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            jtag_pend  <= 1'b0;
            jtag_we    <= 1'b0;
            jtag_wdata <= '0;
            jtag_addr  <= '0;
            mon_err    <= 1'b0;
        end else begin
            if (jtag_done) begin
                jtag_pend <= 1'b0;
                jtag_addr <= jtag_addr + ADDR_W'(1);
            end
            if (jtag_abort) begin
                jtag_pend <= 1'b0;
                mon_err   <= 1'b1;
            end
            if (take_action_ocimem_a) begin
                if (jtag_pend) begin
                    mon_err <= 1'b1;
                end else begin
                    jtag_addr <= jdo[ADDR_W-1:0];
                    if (jdo[35]) begin
                        jtag_pend <= 1'b1;
                        jtag_we   <= 1'b0;
                    end
                    // A simultaneous ocimem_b is discarded but flagged.
                    mon_err <= take_action_ocimem_b;
                end
            end else if (take_action_ocimem_b) begin
                if (jtag_pend) begin
                    mon_err <= 1'b1;
                end else begin
                    jtag_pend  <= 1'b1;
                    jtag_we    <= 1'b1;
                    jtag_wdata <= jdo[DATA_W+2:3];
                    mon_err    <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_cpu_debug_ocimem_arbiter.sv
// ---------------------------------------------------------------------------
// Testbench for cpu_debug_ocimem_arbiter (TIMEOUT = 4).
// A table of JTAG read/write vectors with hand-computed expectations is run
// first, followed by directed sequences for arbitration, wait states,
// timeouts, overrun and reset in the middle of an access.
// ---------------------------------------------------------------------------
module tb_cpu_debug_ocimem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        take_a, take_b;
    logic [37:0] jdo;
    logic [31:0] MonDReg;
    logic        monitor_ready, monitor_error;
    logic        hst_req, hst_wr;
    logic [7:0]  hst_addr;
    logic [31:0] hst_wdata;
    logic        hst_gnt, hst_rvalid, hst_err;
    logic [31:0] hst_rdata;
    logic        mem_req, mem_we, mem_wait;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    cpu_debug_ocimem_arbiter #(.ADDR_W(8), .DATA_W(32), .TIMEOUT(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .take_action_ocimem_a(take_a), .take_action_ocimem_b(take_b),
        .jdo(jdo), .MonDReg(MonDReg),
        .monitor_ready(monitor_ready), .monitor_error(monitor_error),
        .hst_req(hst_req), .hst_wr(hst_wr), .hst_addr(hst_addr),
        .hst_wdata(hst_wdata), .hst_gnt(hst_gnt), .hst_rvalid(hst_rvalid),
        .hst_rdata(hst_rdata), .hst_err(hst_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wait(mem_wait), .mem_rdata(mem_rdata)
    );

    int checks = 0;
    int errors = 0;

    // Bus observer: accepted accesses, owner order (1 = host) and pulses.
    int          acc_cnt = 0, wr_cnt = 0, gnt_cnt = 0, rv_cnt = 0, err_cnt = 0;
    logic [31:0] last_wdata = 32'h0;
    logic        order_q[$];

    always @(negedge clk) begin
        if (mem_req && !mem_wait) begin
            acc_cnt <= acc_cnt + 1;
            order_q.push_back(hst_gnt);
            if (mem_we) begin
                wr_cnt     <= wr_cnt + 1;
                last_wdata <= mem_wdata;
            end
        end
        if (hst_gnt)    gnt_cnt <= gnt_cnt + 1;
        if (hst_rvalid) rv_cnt  <= rv_cnt + 1;
        if (hst_err)    err_cnt <= err_cnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        take_a = 1'b0; take_b = 1'b0; hst_req = 1'b0; mem_wait = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    // One-cycle JTAG pulse; returns 1 time unit after the sampling edge.
    task automatic pulse(input logic a, input logic b, input logic [37:0] j);
        @(posedge clk); #1;
        take_a = a; take_b = b; jdo = j;
        @(posedge clk); #1;
        take_a = 1'b0; take_b = 1'b0;
    endtask

    task automatic wait_ready(input string name);
        logic got;
        got = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (monitor_ready) begin got = 1'b1; break; end
        end
        chk(name, 32'(got), 32'd1);
    endtask

    task automatic wait_gnt(input string name);
        logic got;
        got = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (hst_gnt) begin got = 1'b1; break; end
        end
        chk(name, 32'(got), 32'd1);
    endtask

    task automatic wait_req(input string name);
        logic got;
        got = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (mem_req) begin got = 1'b1; break; end
        end
        chk(name, 32'(got), 32'd1);
    endtask

    function automatic logic [37:0] jrd(input logic [7:0] a);
        logic [37:0] j;
        j = '0; j[7:0] = a; j[35] = 1'b1;
        return j;
    endfunction

    function automatic logic [37:0] jwr(input logic [31:0] d);
        logic [37:0] j;
        j = '0; j[34:3] = d;
        return j;
    endfunction

    typedef struct {
        logic        is_wr;
        logic [7:0]  addr;       // used by reads (ocimem_a loads it)
        logic [31:0] wdata;
        logic [31:0] rdata;      // value the memory returns
        logic [7:0]  exp_addr;
        logic [31:0] exp_mondreg;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int          lat, rc, gk, rk, base, base2;
        logic        seen;
        logic [31:0] rdat;
        logic [37:0] j;
        logic        exp_order[4];

        take_a = 1'b0; take_b = 1'b0; jdo = '0;
        hst_req = 1'b0; hst_wr = 1'b0; hst_addr = '0; hst_wdata = '0;
        mem_wait = 1'b0; mem_rdata = '0; reset_n = 1'b0;

        vecs[0] = '{1'b0, 8'h10, 32'h0,        32'hDEADBEEF, 8'h10, 32'hDEADBEEF};
        vecs[1] = '{1'b1, 8'h00, 32'hCAFEF00D, 32'hFFFFFFFF, 8'h11, 32'hDEADBEEF};
        vecs[2] = '{1'b0, 8'hFE, 32'h0,        32'h01020304, 8'hFE, 32'h01020304};
        vecs[3] = '{1'b1, 8'h00, 32'h12345678, 32'hFFFFFFFF, 8'hFF, 32'h01020304};
        vecs[4] = '{1'b1, 8'h00, 32'hA5A5A5A5, 32'hFFFFFFFF, 8'h00, 32'h01020304};
        vecs[5] = '{1'b1, 8'h00, 32'h0F0F0F0F, 32'hFFFFFFFF, 8'h01, 32'h01020304};
        vecs[6] = '{1'b0, 8'h80, 32'h0,        32'h55AA55AA, 8'h80, 32'h55AA55AA};

        // ---------------- reset state ----------------
        do_reset();
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_ready", 32'(monitor_ready), 32'd1);
        chk("rst_error", 32'(monitor_error), 32'd0);
        chk("rst_mondreg", MonDReg, 32'h0);
        chk("rst_hst_gnt", 32'(hst_gnt), 32'd0);
        chk("rst_hst_rvalid", 32'(hst_rvalid), 32'd0);
        chk("rst_hst_err", 32'(hst_err), 32'd0);
        chk("rst_hst_rdata", hst_rdata, 32'h0);
        $display("reset: ready=%0b error=%0b mem_req=%0b", monitor_ready, monitor_error, mem_req);

        // ---------------- JTAG vector table ----------------
        for (int i = 0; i < 7; i++) begin
            mem_rdata = vecs[i].rdata;
            mem_wait  = 1'b0;
            if (vecs[i].is_wr) pulse(1'b0, 1'b1, jwr(vecs[i].wdata));
            else               pulse(1'b1, 1'b0, jrd(vecs[i].addr));
            chk("vec_ready_low", 32'(monitor_ready), 32'd0);
            lat = 0; seen = 1'b0;
            for (int k = 1; k <= 12; k++) begin
                @(posedge clk); #1;
                if (mem_req && !seen) begin
                    seen = 1'b1;
                    chk("vec_addr", 32'(mem_addr), 32'(vecs[i].exp_addr));
                    chk("vec_we", 32'(mem_we), 32'(vecs[i].is_wr));
                    if (vecs[i].is_wr) chk("vec_wdata", mem_wdata, vecs[i].wdata);
                end
                if (monitor_ready) begin lat = k; break; end
            end
            chk("vec_req_seen", 32'(seen), 32'd1);
            chk("vec_latency", lat, vecs[i].is_wr ? 32'd3 : 32'd4);
            chk("vec_mondreg", MonDReg, vecs[i].exp_mondreg);
            chk("vec_error", 32'(monitor_error), 32'd0);
            $display("vec %0d: %s addr=0x%02h lat=%0d MonDReg=0x%08h", i,
                     vecs[i].is_wr ? "wr" : "rd", mem_addr, lat, MonDReg);
        end

        // ---------------- arbitration: JTAG, HOST, JTAG, HOST ----------------
        do_reset();
        mem_rdata = 32'h600D0001;
        order_q.delete();
        base = gnt_cnt; base2 = rv_cnt;
        fork
            begin
                pulse(1'b1, 1'b0, jrd(8'h40));
                wait_ready("arb_j1_done");
                pulse(1'b1, 1'b0, jrd(8'h41));
                wait_ready("arb_j2_done");
            end
            begin
                // Raise host request once the JTAG slot is already full.
                repeat (2) @(posedge clk);
                #1;
                hst_wr = 1'b0; hst_addr = 8'h33; hst_req = 1'b1;
                wait_gnt("arb_h1_gnt");
                @(posedge clk); #1;
                hst_addr = 8'h34;
                wait_gnt("arb_h2_gnt");
                @(posedge clk); #1;
                hst_req = 1'b0;
            end
        join
        repeat (6) @(posedge clk);
        #1;
        exp_order[0] = 1'b0; exp_order[1] = 1'b1;
        exp_order[2] = 1'b0; exp_order[3] = 1'b1;
        chk("arb_count", order_q.size(), 32'd4);
        for (int i = 0; i < 4 && i < order_q.size(); i++)
            chk("arb_order", 32'(order_q[i]), 32'(exp_order[i]));
        chk("arb_gnt_pulses", gnt_cnt - base, 32'd2);
        chk("arb_rvalid_pulses", rv_cnt - base2, 32'd2);
        $display("arb: %0d accesses, hst_gnt pulses=%0d", order_q.size(), gnt_cnt - base);

        // ---------------- host read with 3 wait cycles ----------------
        mem_rdata = 32'h0BADF00D;
        mem_wait = 1'b1; hst_wr = 1'b0; hst_addr = 8'h22;
        rc = 0; gk = -1; rk = -1; rdat = '0;
        base = gnt_cnt; base2 = rv_cnt;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (k == 0) hst_req = 1'b1;
            if (gk >= 0) hst_req = 1'b0;
            mem_wait = (rc < 3);
            @(negedge clk);
            if (mem_req) begin
                rc++;
                if (rc == 1) chk("hrd_addr", 32'(mem_addr), 32'h22);
            end
            if (hst_gnt) gk = k;
            if (hst_rvalid) begin rk = k; rdat = hst_rdata; end
        end
        chk("hrd_req_cycles", rc, 32'd4);
        chk("hrd_gnt_pulses", gnt_cnt - base, 32'd1);
        chk("hrd_rvalid_pulses", rv_cnt - base2, 32'd1);
        chk("hrd_rvalid_delay", rk - gk, 32'd1);
        chk("hrd_rdata", rdat, 32'h0BADF00D);
        $display("host rd: req_cycles=%0d rdata=0x%08h", rc, rdat);

        // ---------------- host write timeout ----------------
        mem_wait = 1'b1; hst_wr = 1'b1; hst_addr = 8'h44; hst_wdata = 32'h44440000;
        rc = 0; gk = -1;
        base = gnt_cnt; base2 = err_cnt;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (k == 0) hst_req = 1'b1;
            if (gk >= 0) hst_req = 1'b0;
            @(negedge clk);
            if (mem_req) rc++;
            if (hst_err) gk = k;
        end
        chk("hto_req_cycles", rc, 32'd4);
        chk("hto_err_pulses", err_cnt - base2, 32'd1);
        chk("hto_no_gnt", gnt_cnt - base, 32'd0);
        $display("host timeout: req_cycles=%0d", rc);

        // ---------------- JTAG write timeout, then recovery ----------------
        mem_wait = 1'b1;
        j = '0; j[7:0] = 8'h50;                 // address load only
        pulse(1'b1, 1'b0, j);
        chk("jto_addr_only_ready", 32'(monitor_ready), 32'd1);
        base = wr_cnt;
        pulse(1'b0, 1'b1, jwr(32'h11112222));
        rc = 0; seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (mem_req) rc++;
            if (monitor_ready) begin seen = 1'b1; break; end
        end
        chk("jto_finished", 32'(seen), 32'd1);
        chk("jto_req_cycles", rc, 32'd4);
        chk("jto_error", 32'(monitor_error), 32'd1);
        chk("jto_no_write", wr_cnt - base, 32'd0);
        mem_wait = 1'b0;
        pulse(1'b0, 1'b1, jwr(32'h33334444));
        chk("jto_error_cleared", 32'(monitor_error), 32'd0);
        wait_req("jto_retry_req");
        chk("jto_addr_kept", 32'(mem_addr), 32'h50);
        chk("jto_retry_wdata", mem_wdata, 32'h33334444);
        wait_ready("jto_retry_done");
        $display("jtag timeout: req_cycles=%0d retry addr=0x%02h", rc, mem_addr);

        // ---------------- overrun: second write while first in flight ----------------
        base = wr_cnt;
        pulse(1'b0, 1'b1, jwr(32'hAAAA0001));
        pulse(1'b0, 1'b1, jwr(32'hBBBB0002));
        chk("ovr_error", 32'(monitor_error), 32'd1);
        wait_ready("ovr_done");
        repeat (2) @(posedge clk);
        #1;
        chk("ovr_one_write", wr_cnt - base, 32'd1);
        chk("ovr_wdata", last_wdata, 32'hAAAA0001);
        chk("ovr_error_sticky", 32'(monitor_error), 32'd1);
        $display("overrun: writes=%0d data=0x%08h", wr_cnt - base, last_wdata);

        // ---------------- simultaneous ocimem_a (read) and ocimem_b ----------------
        base = wr_cnt;
        mem_rdata = 32'h7777AAAA;
        j = jwr(32'h00DEAD00); j[7:0] = 8'h60; j[35] = 1'b1;
        pulse(1'b1, 1'b1, j);
        chk("sim_ready_low", 32'(monitor_ready), 32'd0);
        chk("sim_error", 32'(monitor_error), 32'd1);
        wait_req("sim_req");
        chk("sim_addr", 32'(mem_addr), 32'h60);
        chk("sim_is_read", 32'(mem_we), 32'd0);
        wait_ready("sim_done");
        chk("sim_mondreg", MonDReg, 32'h7777AAAA);
        chk("sim_no_write", wr_cnt - base, 32'd0);
        $display("a+b: addr=0x60 MonDReg=0x%08h", MonDReg);

        // ---------------- reset in the middle of ISSUE ----------------
        mem_wait = 1'b1;
        pulse(1'b1, 1'b0, jrd(8'h70));
        wait_req("mrst_req");
        reset_n = 1'b0;
        #1;
        chk("mrst_mem_req", 32'(mem_req), 32'd0);
        chk("mrst_ready", 32'(monitor_ready), 32'd1);
        chk("mrst_error", 32'(monitor_error), 32'd0);
        chk("mrst_mondreg", MonDReg, 32'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        mem_wait = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("mrst_stays_idle", 32'(mem_req), 32'd0);
        $display("mid-access reset: mem_req=%0b ready=%0b", mem_req, monitor_ready);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
